// File: rtl/rf_pkg.sv
// Shared types and helpers for the parametrised register file.
//
// Contents:
//   rf_state_t   - sequencer state: INIT (preset load running) or READY.
//   rf_init_val  - preset value for entry idx, i.e. (idx + 1) truncated to width bits.
package rf_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } rf_state_t;

  // Result is 32 bits wide; callers cast it to their data width. For width >= 32 the
  // value is returned unmasked, and wider callers zero-extend it.
  function automatic logic [31:0] rf_init_val(input int unsigned idx, input int unsigned width);
    logic [31:0] val;
    val = idx + 32'd1;
    if (width < 32) begin
      val = val & ((32'd1 << width) - 32'd1);
    end
    return val;
  endfunction

endpackage

// File: rtl/rf_init_seq.sv
// Self-initialisation sequencer for param_register_file.
//
// After every reset it walks the counter from 0 to DEPTH-1, issuing one preset write per
// cycle, and then parks in READY.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   init_we    out  preset write strobe (high for the whole INIT phase)
//   init_addr  out  preset write address
//   init_data  out  preset write data, rf_init_val(init_addr)
//   ready      out  registered; high from the first READY cycle on
module rf_init_seq
  import rf_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  output logic             init_we,
  output logic [AW-1:0]    init_addr,
  output logic [WIDTH-1:0] init_data,
  output logic             ready
);

  localparam logic [AW-1:0] LastIdx = AW'(DEPTH - 1);

  rf_state_t       state;
  logic [AW-1:0]   cnt;

  // Single-process FSM; ready is registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT;
      cnt   <= '0;
      ready <= 1'b0;
    end else begin
      unique case (state)
        INIT: begin
          if (cnt == LastIdx) begin
            state <= READY;
            ready <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        READY: begin
          ready <= 1'b1;
        end
        default: begin
          state <= INIT;
          cnt   <= '0;
          ready <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    init_we   = (state == INIT);
    init_addr = cnt;
    init_data = WIDTH'(rf_init_val(32'(cnt), WIDTH));
  end

endmodule

// File: rtl/param_register_file.sv
// Parametrised WIDTH x DEPTH register file: two registered read ports, one write port.
// After each reset the contents are reloaded with presets (entry i = i+1) by rf_init_seq;
// external accesses are honoured only once ready is high.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   we, waddr, wdata  write port (out-of-range or pre-ready writes are dropped, werr pulses)
//   re, raddr1/2      read enable (both ports) and read addresses
//   rdata1/2, rvalid  registered read data, valid the cycle after an accepted read
//   ready             initialisation complete
//   werr              one-cycle pulse for each dropped write
//
// Build option: define RF_FORWARD_EN to forward wdata onto a read port whose address
// collides with an in-range write in the same cycle; otherwise reads return old content.
module param_register_file
  import rf_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr1,
  input  logic [AW-1:0]    raddr2,
  output logic [WIDTH-1:0] rdata1,
  output logic [WIDTH-1:0] rdata2,
  output logic             rvalid,
  output logic             ready,
  output logic             werr
);

  // One extra bit so DEPTH itself is representable for the range compares.
  localparam logic [AW:0] DepthW = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic             init_we;
  logic [AW-1:0]    init_addr;
  logic [WIDTH-1:0] init_data;

  logic             waddr_ok, raddr1_ok, raddr2_ok;
  logic             ext_wr;
  logic             mem_we;
  logic [AW-1:0]    mem_addr;
  logic [WIDTH-1:0] mem_data;
  logic [WIDTH-1:0] rd1, rd2;
  logic             werr_d;

  rf_init_seq #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_init_seq (
    .clk       (clk),
    .rst       (rst),
    .init_we   (init_we),
    .init_addr (init_addr),
    .init_data (init_data),
    .ready     (ready)
  );

  always_comb begin
    waddr_ok  = ({1'b0, waddr} < DepthW);
    raddr1_ok = ({1'b0, raddr1} < DepthW);
    raddr2_ok = ({1'b0, raddr2} < DepthW);
    ext_wr    = ready & we & waddr_ok;
    // While not ready a write is dropped regardless of address.
    werr_d    = we & (~ready | ~waddr_ok);
  end

  // The sequencer owns the array during INIT; ready and init_we are mutually exclusive.
  always_comb begin
    mem_we   = init_we | ext_wr;
    mem_addr = init_we ? init_addr : waddr;
    mem_data = init_we ? init_data : wdata;
  end

  // Storage is deliberately not reset; the sequencer reloads it after every reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_data;
    end
  end

  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (raddr1_ok) begin
      rd1 = mem[raddr1];
    end
    if (raddr2_ok) begin
      rd2 = mem[raddr2];
    end
`ifdef RF_FORWARD_EN
    // ext_wr already excludes out-of-range writes, so those are never forwarded.
    if (ext_wr && (raddr1 == waddr)) begin
      rd1 = wdata;
    end
    if (ext_wr && (raddr2 == waddr)) begin
      rd2 = wdata;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata1 <= '0;
      rdata2 <= '0;
      rvalid <= 1'b0;
      werr   <= 1'b0;
    end else begin
      werr <= werr_d;
      if (ready && re) begin
        rdata1 <= rd1;
        rdata2 <= rd2;
        rvalid <= 1'b1;
      end else begin
        rvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_param_register_file.sv
// Bench for param_register_file: one DEPTH=8 and one DEPTH=6 instance share a stimulus
// stream. A per-instance behavioural model predicts every output each cycle; directed
// literal checks pin the model at the points called out by the test plan.
module tb_param_register_file;

`ifdef RF_FORWARD_EN
  localparam bit Fwd = 1'b1;
`else
  localparam bit Fwd = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       we;
  logic [2:0] waddr;
  logic [7:0] wdata;
  logic       re;
  logic [2:0] raddr1;
  logic [2:0] raddr2;

  logic [7:0] d_rd1 [2];
  logic [7:0] d_rd2 [2];
  logic       d_rv [2];
  logic       d_rdy [2];
  logic       d_werr [2];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  param_register_file #(.WIDTH(8), .DEPTH(8)) u_dut8 (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .re     (re),
    .raddr1 (raddr1),
    .raddr2 (raddr2),
    .rdata1 (d_rd1[0]),
    .rdata2 (d_rd2[0]),
    .rvalid (d_rv[0]),
    .ready  (d_rdy[0]),
    .werr   (d_werr[0])
  );

  param_register_file #(.WIDTH(8), .DEPTH(6)) u_dut6 (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .re     (re),
    .raddr1 (raddr1),
    .raddr2 (raddr2),
    .rdata1 (d_rd1[1]),
    .rdata2 (d_rd2[1]),
    .rvalid (d_rv[1]),
    .ready  (d_rdy[1]),
    .werr   (d_werr[1])
  );

  // ---------------- behavioural model ----------------
  int         mdepth [2] = '{8, 6};
  int         mmem [2][8];
  bit         mrdy [2];
  int         mk [2];
  logic [7:0] e_rd1 [2];
  logic [7:0] e_rd2 [2];
  bit         e_rv [2];
  bit         e_rdy [2];
  bit         e_werr [2];
  bit         started = 1'b0;

  function automatic logic [7:0] model_read(input int i, input int addr);
    if (addr >= mdepth[i]) return 8'h00;
    if (Fwd && we && (int'(waddr) < mdepth[i]) && (int'(waddr) == addr)) return wdata;
    return 8'(mmem[i][addr]);
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        mrdy[i]   = 1'b0;
        mk[i]     = 0;
        e_rd1[i]  = 8'h00;
        e_rd2[i]  = 8'h00;
        e_rv[i]   = 1'b0;
        e_rdy[i]  = 1'b0;
        e_werr[i] = 1'b0;
      end else if (started) begin
        if (!mrdy[i]) begin
          // Preset phase: one entry per cycle, external accesses refused.
          e_werr[i] = we;
          e_rv[i]   = 1'b0;
          mmem[i][mk[i]] = (mk[i] + 1) % 256;
          mk[i] = mk[i] + 1;
          if (mk[i] == mdepth[i]) mrdy[i] = 1'b1;
        end else begin
          e_werr[i] = we && (int'(waddr) >= mdepth[i]);
          e_rv[i]   = re;
          if (re) begin
            e_rd1[i] = model_read(i, int'(raddr1));
            e_rd2[i] = model_read(i, int'(raddr2));
          end
          if (we && (int'(waddr) < mdepth[i])) mmem[i][waddr] = int'(wdata);
        end
        e_rdy[i] = mrdy[i];
      end
    end
    if (rst) started = 1'b1;
  end

  task automatic cmp(input string name, input int i, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: actual=%0h required=%0h at %0t", name, i, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < 2; i++) begin
        cmp("ready", i, 32'(d_rdy[i]), 32'(e_rdy[i]));
        cmp("rvalid", i, 32'(d_rv[i]), 32'(e_rv[i]));
        cmp("werr", i, 32'(d_werr[i]), 32'(e_werr[i]));
        cmp("rdata1", i, 32'(d_rd1[i]), 32'(e_rd1[i]));
        cmp("rdata2", i, 32'(d_rd2[i]), 32'(e_rd2[i]));
      end
    end
  end

  task automatic cycle();
    @(negedge clk);
  endtask

  task automatic idle();
    we = 1'b0;
    re = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; re = 1'b0; raddr1 = '0; raddr2 = '0;
    cycle();
    rst = 1'b0;
    cycle();                                    // INIT edge 1
    // Write and read attempted during INIT edge 2: both refused.
    we = 1'b1; waddr = 3'd2; wdata = 8'hEE; re = 1'b1; raddr1 = 3'd1;
    cycle();
    cmp("lit_werr_init", 0, 32'(d_werr[0]), 32'd1);
    cmp("lit_rvalid_init", 0, 32'(d_rv[0]), 32'd0);
    idle();
    cycle();
    cmp("lit_werr_clear", 0, 32'(d_werr[0]), 32'd0);
    repeat (3) cycle();                          // 6 edges since reset released
    cmp("lit_ready6", 1, 32'(d_rdy[1]), 32'd1);
    cmp("lit_ready8_early", 0, 32'(d_rdy[0]), 32'd0);
    cycle();
    cmp("lit_ready8_edge7", 0, 32'(d_rdy[0]), 32'd0);
    cycle();
    cmp("lit_ready8_edge8", 0, 32'(d_rdy[0]), 32'd1);

    // Preset read.
    re = 1'b1; raddr1 = 3'd0; raddr2 = 3'd6;
    cycle();
    idle();
    cmp("lit_preset0", 0, 32'(d_rd1[0]), 32'h01);
    cmp("lit_preset6", 0, 32'(d_rd2[0]), 32'h07);
    cmp("lit_rvalid", 0, 32'(d_rv[0]), 32'd1);
    cmp("lit_oor_read6", 1, 32'(d_rd2[1]), 32'h00);
    cycle();
    cmp("lit_rvalid_drop", 0, 32'(d_rv[0]), 32'd0);
    cmp("lit_hold", 0, 32'(d_rd1[0]), 32'h01);

    // Write then read back.
    we = 1'b1; waddr = 3'd3; wdata = 8'hA5;
    cycle();
    idle();
    re = 1'b1; raddr1 = 3'd3;
    cycle();
    idle();
    cmp("lit_wr_rd", 0, 32'(d_rd1[0]), 32'hA5);

    // Same-cycle collision on entry 2 (INIT write attempt must not have landed).
    we = 1'b1; waddr = 3'd2; wdata = 8'h5C; re = 1'b1; raddr1 = 3'd2; raddr2 = 3'd5;
    cycle();
    idle();
    cmp("lit_collide", 0, 32'(d_rd1[0]), Fwd ? 32'h5C : 32'h03);
    re = 1'b1; raddr1 = 3'd2;
    cycle();
    idle();
    cmp("lit_after_collide", 0, 32'(d_rd1[0]), 32'h5C);

    // Out-of-range write for the DEPTH=6 instance, in range for DEPTH=8.
    we = 1'b1; waddr = 3'd7; wdata = 8'h77;
    cycle();
    idle();
    cmp("lit_werr_oor", 1, 32'(d_werr[1]), 32'd1);
    cmp("lit_werr_inrange", 0, 32'(d_werr[0]), 32'd0);
    cycle();
    cmp("lit_werr_pulse", 1, 32'(d_werr[1]), 32'd0);
    // Sweep every address on both ports (same address on each) to check no entry moved.
    for (int a = 0; a < 8; a++) begin
      re = 1'b1; raddr1 = 3'(a); raddr2 = 3'(a);
      cycle();
    end
    idle();
    cmp("lit_entry7", 0, 32'(d_rd1[0]), 32'h77);
    cmp("lit_oor_read7", 1, 32'(d_rd2[1]), 32'h00);

    // Overwrite entry 4, then reset mid-operation.
    we = 1'b1; waddr = 3'd4; wdata = 8'hFF;
    cycle();
    idle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    cmp("lit_ready_drop", 0, 32'(d_rdy[0]), 32'd0);
    cmp("lit_rdata_clr", 0, 32'(d_rd1[0]), 32'h00);
    re = 1'b1; raddr1 = 3'd4;
    cycle();
    idle();
    cmp("lit_rvalid_reinit", 0, 32'(d_rv[0]), 32'd0);
    repeat (7) cycle();
    cmp("lit_ready_again", 0, 32'(d_rdy[0]), 32'd1);
    re = 1'b1; raddr1 = 3'd4; raddr2 = 3'd3;
    cycle();
    idle();
    cmp("lit_represet4", 0, 32'(d_rd1[0]), 32'h05);
    cmp("lit_represet3", 0, 32'(d_rd2[0]), 32'h04);

    // Back-to-back write/read pattern across both ports.
    for (int a = 0; a < 8; a++) begin
      we = 1'b1; waddr = 3'(a); wdata = 8'(8'h30 + a);
      re = 1'b1; raddr1 = 3'(a); raddr2 = 3'(7 - a);
      cycle();
    end
    idle();
    cycle();
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
